// File: rtl/core_pkg.sv
// Shared core definitions: architectural width, reset/bubble constants and
// the fetch stage state encoding.
package core_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } fetch_state_t;

endpackage : core_pkg

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem read per fetch_enable,
// folds exec redirects into the next fetch address and squashes wrong-path words.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
   parameter logic [XLEN-1:0] NOP_INSN = core_pkg::NOP_INSN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_enable,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            fetch_done,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic            instr_valid,
   output logic            misaligned
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            imem_req_q, imem_req_d;
   logic [XLEN-1:0] imem_addr_q, imem_addr_d;
   logic            redirect_pending_q, redirect_pending_d;
   logic [XLEN-1:0] redir_tgt_q, redir_tgt_d;
   logic            squash_q, squash_d;
   logic            fetch_done_q, fetch_done_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;
   logic            instr_valid_q, instr_valid_d;
   logic            misaligned_q, misaligned_d;

   logic [XLEN-1:0] fetch_addr;
   logic            squash_now;

   // A redirect arriving in the same cycle as the enable is bypassed into the address.
   always_comb begin
      fetch_addr = branch_taken       ? branch_target :
                   redirect_pending_q ? redir_tgt_q   : pc_q;
      fetch_addr[1:0] = 2'b00;
   end

   assign squash_now = squash_q | branch_taken;

   // NOTE: every *_d gets its hold value first, so no path can infer a latch.
   always_comb begin
      state_d            = state_q;
      pc_d               = pc_q;
      imem_req_d         = 1'b0;
      imem_addr_d        = imem_addr_q;
      redirect_pending_d = redirect_pending_q;
      redir_tgt_d        = redir_tgt_q;
      squash_d           = squash_q;
      fetch_done_d       = 1'b0;
      instr_d            = instr_q;
      instr_pc_d         = instr_pc_q;
      instr_valid_d      = instr_valid_q;
      misaligned_d       = misaligned_q;

      if (branch_taken && (branch_target[1:0] != 2'b00)) begin
         misaligned_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            // imem_rvalid is deliberately ignored here: it can only be a stale response.
            if (fetch_enable) begin
               imem_req_d         = 1'b1;
               imem_addr_d        = fetch_addr;
               redirect_pending_d = 1'b0;
               squash_d           = 1'b0;
               state_d            = WAIT;
            end else if (branch_taken) begin
               redirect_pending_d = 1'b1;
               redir_tgt_d        = branch_target;
            end
         end

         WAIT: begin
            if (imem_rvalid) begin
               fetch_done_d  = 1'b1;
               instr_d       = squash_now ? NOP_INSN : imem_rdata;
               instr_valid_d = ~squash_now;
               instr_pc_d    = imem_addr_q;
               pc_d          = imem_addr_q + XLEN'(4);
               squash_d      = 1'b0;
               state_d       = IDLE;
            end else if (branch_taken) begin
               squash_d = 1'b1;
            end
            if (branch_taken) begin
               redirect_pending_d = 1'b1;
               redir_tgt_d        = branch_target;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment only; rst is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= IDLE;
         pc_q               <= RESET_PC;
         imem_req_q         <= 1'b0;
         imem_addr_q        <= RESET_PC;
         redirect_pending_q <= 1'b0;
         redir_tgt_q        <= RESET_PC;
         squash_q           <= 1'b0;
         fetch_done_q       <= 1'b0;
         instr_q            <= NOP_INSN;
         instr_pc_q         <= RESET_PC;
         instr_valid_q      <= 1'b0;
         misaligned_q       <= 1'b0;
      end else begin
         state_q            <= state_d;
         pc_q               <= pc_d;
         imem_req_q         <= imem_req_d;
         imem_addr_q        <= imem_addr_d;
         redirect_pending_q <= redirect_pending_d;
         redir_tgt_q        <= redir_tgt_d;
         squash_q           <= squash_d;
         fetch_done_q       <= fetch_done_d;
         instr_q            <= instr_d;
         instr_pc_q         <= instr_pc_d;
         instr_valid_q      <= instr_valid_d;
         misaligned_q       <= misaligned_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign fetch_done  = fetch_done_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign misaligned  = misaligned_q;

   // The stall controller must never pulse fetch_enable while a fetch is in flight.
   a_no_enable_in_wait : assert property (
      @(posedge clk) disable iff (rst) !(fetch_enable && (state_q == WAIT))
   ) else $warning("fetch_unit: fetch_enable ignored while a fetch is in flight");

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task drives one scenario against a
// behavioural instruction memory and checks hand-computed results inline.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_enable;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        fetch_done;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        misaligned;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_enable  (fetch_enable),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .fetch_done    (fetch_done),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .misaligned    (misaligned)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // One fetch: enable at cycle 0, rvalid driven in cycle 'lat', optional
   // branch in cycle br_cyc (0 = with the enable), optional stray enable in inj_cyc.
   task automatic run_fetch(input int lat, input logic [31:0] data,
                            input int br_cyc, input logic [31:0] br_tgt,
                            input int inj_cyc,
                            output int done_cyc, output int req_cnt,
                            output logic [31:0] addr, output logic addr_held);
      int cyc;
      fetch_enable  = 1'b1;
      branch_taken  = (br_cyc == 0);
      branch_target = br_tgt;
      step;
      fetch_enable = 1'b0;
      branch_taken = 1'b0;
      cyc       = 1;
      done_cyc  = -1;
      req_cnt   = 0;
      addr      = imem_addr;
      addr_held = 1'b1;
      while (cyc < 40 && done_cyc < 0) begin
         if (imem_req === 1'b1) req_cnt++;
         if (fetch_done === 1'b1) begin
            done_cyc = cyc;
         end else begin
            if (imem_addr !== addr) addr_held = 1'b0;
            imem_rvalid   = (cyc == lat);
            imem_rdata    = data;
            branch_taken  = (br_cyc == cyc);
            branch_target = br_tgt;
            fetch_enable  = (inj_cyc == cyc);
            step;
            cyc++;
            imem_rvalid  = 1'b0;
            branch_taken = 1'b0;
            fetch_enable = 1'b0;
         end
      end
   endtask

   task automatic redirect_idle(input logic [31:0] tgt);
      branch_taken  = 1'b1;
      branch_target = tgt;
      step;
      branch_taken  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; fetch_enable = 1'b0; branch_taken = 1'b0; branch_target = '0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      step; step;
      rst = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
      checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", fetch_done); end
      checks++; if (instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
   endtask

   task automatic test_basic;
      int d, r; logic [31:0] a; logic h;
      run_fetch(1, 32'h0050_0093, -1, 32'h0, -1, d, r, a, h);
      checks++; if (a !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h want 0", a); end
      checks++; if (d !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", d); end
      checks++; if (r !== 1) begin errors++; $display("FAIL basic_req_count: got %0d want 1", r); end
      checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr: got %h want 00500093", instr); end
      checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL basic_instr_pc: got %h want 0", instr_pc); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", instr_valid); end
      step;
      checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", fetch_done); end
      checks++; if (instr !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr_hold: got %h want 00500093", instr); end
      run_fetch(1, 32'h0010_0113, -1, 32'h0, -1, d, r, a, h);
      checks++; if (a !== 32'h4) begin errors++; $display("FAIL basic_next_addr: got %h want 4", a); end
      checks++; if (instr_pc !== 32'h4) begin errors++; $display("FAIL basic_next_pc: got %h want 4", instr_pc); end
   endtask

   task automatic test_latency;
      int d, r; logic [31:0] a; logic h;
      run_fetch(5, 32'h0020_8193, -1, 32'h0, 3, d, r, a, h);
      checks++; if (a !== 32'h8) begin errors++; $display("FAIL lat_addr: got %h want 8", a); end
      checks++; if (r !== 1) begin errors++; $display("FAIL lat_req_count: got %0d want 1", r); end
      checks++; if (h !== 1'b1) begin errors++; $display("FAIL lat_addr_held: got %b want 1", h); end
      checks++; if (d !== 6) begin errors++; $display("FAIL lat_latency: got %0d want 6", d); end
      checks++; if (instr !== 32'h0020_8193) begin errors++; $display("FAIL lat_instr: got %h want 00208193", instr); end
      step;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL lat_no_extra_req: got %b want 0", imem_req); end
   endtask

   task automatic test_branch_wait;
      int d, r; logic [31:0] a; logic h;
      run_fetch(3, 32'hDEAD_BEEF, 2, 32'h0000_0100, -1, d, r, a, h);
      checks++; if (a !== 32'hC) begin errors++; $display("FAIL bw_addr: got %h want c", a); end
      checks++; if (instr !== NOP) begin errors++; $display("FAIL bw_instr: got %h want %h", instr, NOP); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bw_valid: got %b want 0", instr_valid); end
      checks++; if (instr_pc !== 32'hC) begin errors++; $display("FAIL bw_instr_pc: got %h want c", instr_pc); end
      run_fetch(1, 32'h1111_1111, -1, 32'h0, -1, d, r, a, h);
      checks++; if (a !== 32'h100) begin errors++; $display("FAIL bw_next_addr: got %h want 100", a); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bw_next_valid: got %b want 1", instr_valid); end
   endtask

   task automatic test_branch_with_rvalid;
      int d, r; logic [31:0] a; logic h;
      run_fetch(2, 32'h3333_3333, 2, 32'h0000_0300, -1, d, r, a, h);
      checks++; if (a !== 32'h104) begin errors++; $display("FAIL br_rv_addr: got %h want 104", a); end
      checks++; if (d !== 3) begin errors++; $display("FAIL br_rv_latency: got %0d want 3", d); end
      checks++; if (instr !== NOP || instr_valid !== 1'b0) begin
         errors++; $display("FAIL br_rv_squash: got %h/%b want %h/0", instr, instr_valid, NOP);
      end
      run_fetch(1, 32'h4444_4444, -1, 32'h0, -1, d, r, a, h);
      checks++; if (a !== 32'h300) begin errors++; $display("FAIL br_rv_next_addr: got %h want 300", a); end
   endtask

   task automatic test_branch_with_enable;
      int d, r; logic [31:0] a; logic h;
      run_fetch(1, 32'h2222_2222, 0, 32'h0000_0200, -1, d, r, a, h);
      checks++; if (a !== 32'h200) begin errors++; $display("FAIL be_addr: got %h want 200", a); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL be_valid: got %b want 1", instr_valid); end
      checks++; if (instr !== 32'h2222_2222) begin errors++; $display("FAIL be_instr: got %h want 22222222", instr); end
   endtask

   task automatic test_back_to_back;
      int d, r; logic [31:0] a; logic h;
      redirect_idle(32'h40);
      redirect_idle(32'h80);
      run_fetch(1, 32'h5555_5555, -1, 32'h0, -1, d, r, a, h);
      checks++; if (a !== 32'h80) begin errors++; $display("FAIL b2b_addr: got %h want 80", a); end
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL b2b_aligned: got %b want 0", misaligned); end
      redirect_idle(32'h82);
      checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL b2b_misaligned: got %b want 1", misaligned); end
      run_fetch(1, 32'h6666_6666, -1, 32'h0, -1, d, r, a, h);
      checks++; if (a !== 32'h80) begin errors++; $display("FAIL b2b_mis_addr: got %h want 80", a); end
      checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL b2b_sticky: got %b want 1", misaligned); end
   endtask

   task automatic test_wrap;
      int d, r; logic [31:0] a; logic h;
      redirect_idle(32'hFFFF_FFFC);
      run_fetch(1, 32'h7777_7777, -1, 32'h0, -1, d, r, a, h);
      checks++; if (a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", a); end
      checks++; if (instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_instr_pc: got %h want fffffffc", instr_pc); end
      run_fetch(1, 32'h8888_8888, -1, 32'h0, -1, d, r, a, h);
      checks++; if (a !== 32'h0) begin errors++; $display("FAIL wrap_next_addr: got %h want 0", a); end
   endtask

   task automatic test_rst_mid_wait;
      int d, r; logic [31:0] a; logic h;
      redirect_idle(32'h0000_0500);
      fetch_enable = 1'b1;
      step;
      fetch_enable = 1'b0;
      step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h9999_9999;
      step;
      imem_rvalid = 1'b0;
      checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL rst_stale_done: got %b want 0", fetch_done); end
      checks++; if (instr !== NOP || instr_valid !== 1'b0) begin
         errors++; $display("FAIL rst_stale_instr: got %h/%b want %h/0", instr, instr_valid, NOP);
      end
      checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL rst_misaligned: got %b want 0", misaligned); end
      step;
      checks++; if (fetch_done !== 1'b0) begin errors++; $display("FAIL rst_stale_done2: got %b want 0", fetch_done); end
      run_fetch(1, 32'hAAAA_AAAA, -1, 32'h0, -1, d, r, a, h);
      checks++; if (a !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", a); end
      checks++; if (d !== 2) begin errors++; $display("FAIL rst_next_latency: got %0d want 2", d); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_latency;
      test_branch_wait;
      test_branch_with_rvalid;
      test_branch_with_enable;
      test_back_to_back;
      test_wrap;
      test_rst_mid_wait;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fetch_unit
